// File: rtl/updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_pkg
// Brief    : Shared mode, direction and event encodings for updown_counter_mod.
// Revision : 1.0 - initial release
// ============================================================================
package updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_WRAP = 2'd1,
    EV_SAT  = 2'd2
  } event_e;

endpackage
`default_nettype wire

// File: rtl/updown_counter_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : counter_next_calc
// Brief    : Combinational next-value and wrap/saturate event for one count step.
// Revision : 1.0 - initial release
// ============================================================================
module counter_next_calc
  import updown_counter_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] q,
  input  logic [BITS:0]   s,
  input  logic            up,
  input  logic [BITS-1:0] max_value,
  input  logic            sat_mode,
  output logic [BITS-1:0] q_next,
  output event_e          ev
);

  localparam logic [BITS-1:0] ONE = 1;

  logic [BITS:0]   w_q_ext;
  logic [BITS:0]   w_max_ext;
  logic [BITS:0]   w_sum;
  logic [BITS-1:0] w_s_lo;
  logic            w_out_of_range;
  event_e          w_limit_ev;

  // Wrapped results are always below the modulus, so BITS-wide modular
  // arithmetic gives them exactly; only the comparisons need the extra bit.
  assign w_q_ext        = {1'b0, q};
  assign w_max_ext      = {1'b0, max_value};
  assign w_sum          = w_q_ext + s;
  assign w_s_lo         = s[BITS-1:0];
  assign w_out_of_range = (q > max_value);
  assign w_limit_ev     = (sat_mode == MODE_WRAP) ? EV_WRAP : EV_SAT;

  always_comb begin
    q_next = q;
    ev     = EV_NONE;
    if (up == DIR_UP) begin
      if (w_out_of_range) begin
        q_next = (sat_mode == MODE_SAT) ? max_value : '0;
        ev     = w_limit_ev;
      end else if (w_sum <= w_max_ext) begin
        q_next = q + w_s_lo;
      end else begin
        q_next = (sat_mode == MODE_SAT) ? max_value : (q + w_s_lo - max_value - ONE);
        ev     = w_limit_ev;
      end
    end else if (up == DIR_DOWN) begin
      if (w_out_of_range) begin
        q_next = max_value;
        ev     = w_limit_ev;
      end else if (w_q_ext >= s) begin
        q_next = q - w_s_lo;
      end else begin
        q_next = (sat_mode == MODE_SAT) ? '0 : (q + max_value + ONE - w_s_lo);
        ev     = w_limit_ev;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_mod
// Brief    : Up/down counter with programmable modulus, step and wrap/sat mode.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [BITS-1:0]      load_value,
  input  logic                 enable,
  input  logic                 up,
  input  logic [STEP_BITS-1:0] step,
  input  logic [BITS-1:0]      max_value,
  input  logic                 sat_mode,
  output logic [BITS-1:0]      Q,
  output logic                 wrap_pulse,
  output logic                 sat_pulse,
  output logic                 at_max,
  output logic                 at_min
);

  if (STEP_BITS > BITS) begin : g_step_bits_check
    $error("updown_counter_mod: STEP_BITS must not exceed BITS");
  end

  logic [BITS-1:0] q_q, q_d;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic            sat_pulse_q, sat_pulse_d;

  logic [BITS:0]   w_mod_ext;
  logic [BITS:0]   w_step_ext;
  logic [BITS:0]   w_s;
  logic            w_count;
  logic [BITS-1:0] w_calc_next;
  event_e          w_calc_ev;

  // Clamping the step to the modulus keeps a single update within one wrap.
  assign w_mod_ext  = {1'b0, max_value} + {{BITS{1'b0}}, 1'b1};
  assign w_step_ext = {{(BITS + 1 - STEP_BITS){1'b0}}, step};
  assign w_s        = (w_step_ext > w_mod_ext) ? w_mod_ext : w_step_ext;
  assign w_count    = enable && (step != '0);

  counter_next_calc #(
    .BITS(BITS)
  ) u_next_calc (
    .q        (q_q),
    .s        (w_s),
    .up       (up),
    .max_value(max_value),
    .sat_mode (sat_mode),
    .q_next   (w_calc_next),
    .ev       (w_calc_ev)
  );

  always_comb begin
    q_d          = q_q;
    wrap_pulse_d = 1'b0;
    sat_pulse_d  = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_value > max_value) ? max_value : load_value;
    end else if (w_count) begin
      q_d          = w_calc_next;
      wrap_pulse_d = (w_calc_ev == EV_WRAP);
      sat_pulse_d  = (w_calc_ev == EV_SAT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q          <= '0;
      wrap_pulse_q <= 1'b0;
      sat_pulse_q  <= 1'b0;
    end else begin
      q_q          <= q_d;
      wrap_pulse_q <= wrap_pulse_d;
      sat_pulse_q  <= sat_pulse_d;
    end
  end

  assign Q          = q_q;
  assign wrap_pulse = wrap_pulse_q;
  assign sat_pulse  = sat_pulse_q;
  assign at_max     = (q_q == max_value);
  assign at_min     = (q_q == '0);

endmodule
`default_nettype wire
